// File: rtl/luma_auto_brightness_pkg.sv
// Shared video-filter definitions: controller state encoding, coefficient width
// and the sign-extension helper the brightness filter uses as well.
package luma_auto_brightness_pkg;

  localparam int COE_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_UPD
  } state_t;

  // Replicates bit (src_width-1) of raw into every position above it.
  function automatic logic [COE_WIDTH-1:0] sext_coe(input logic [COE_WIDTH-1:0] raw,
                                                    input int src_width);
    logic [COE_WIDTH-1:0] res;
    for (int i = 0; i < COE_WIDTH; i++) begin
      res[i] = (i < src_width) ? raw[i] : raw[src_width-1];
    end
    return res;
  endfunction

endpackage

// File: rtl/luma_auto_brightness_if.sv
// Video stream in, frame statistics and brightness coefficient out.
interface luma_auto_brightness_if #(
  parameter int PIXEL_WIDTH = 8
);
  import luma_auto_brightness_pkg::*;

  logic                   en_i;
  logic [PIXEL_WIDTH-1:0] target_i;
  logic [PIXEL_WIDTH-1:0] y_i;
  logic                   de_i;
  logic                   hs_i;
  logic                   vs_i;
  logic [COE_WIDTH-1:0]   coe_o;
  logic [PIXEL_WIDTH-1:0] mean_o;
  logic                   upd_o;
  logic                   empty_o;
  logic                   overrun_o;

  modport master (
    output en_i, target_i, y_i, de_i, hs_i, vs_i,
    input  coe_o, mean_o, upd_o, empty_o, overrun_o
  );

  modport slave (
    input  en_i, target_i, y_i, de_i, hs_i, vs_i,
    output coe_o, mean_o, upd_o, empty_o, overrun_o
  );

endinterface

// File: rtl/luma_auto_brightness_udiv_seq.sv
// Restoring unsigned divider: one quotient bit per clock, done pulses exactly
// DIVIDEND_WIDTH cycles after start. The divisor must be non-zero.
module udiv_seq #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 24,
  parameter int QUOTIENT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      busy,
  output logic                      done,
  output logic [QUOTIENT_WIDTH-1:0] quotient
);

  localparam int LEFT_WIDTH = $clog2(DIVIDEND_WIDTH + 1);

  logic [DIVIDEND_WIDTH-1:0] shreg;
  logic [DIVISOR_WIDTH-1:0]  rem;
  logic [DIVISOR_WIDTH-1:0]  dsr;
  logic [LEFT_WIDTH-1:0]     left;
  logic [DIVISOR_WIDTH:0]    trial;
  logic                      fits;

  // shreg shifts dividend bits out of the top while quotient bits enter at the bottom.
  assign trial    = {rem, shreg[DIVIDEND_WIDTH-1]};
  assign fits     = trial >= {1'b0, dsr};
  assign busy     = left != '0;
  assign quotient = shreg[QUOTIENT_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      rem   <= '0;
      dsr   <= '0;
      left  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg <= dividend;
        rem   <= '0;
        dsr   <= divisor;
        left  <= LEFT_WIDTH'(DIVIDEND_WIDTH);
      end else if (busy) begin
        rem   <= fits ? DIVISOR_WIDTH'(trial - {1'b0, dsr}) : trial[DIVISOR_WIDTH-1:0];
        shreg <= {shreg[DIVIDEND_WIDTH-2:0], fits};
        left  <= left - LEFT_WIDTH'(1);
        done  <= (left == LEFT_WIDTH'(1));
      end
    end
  end

endmodule

// File: rtl/luma_auto_brightness.sv
// Auto-brightness controller: accumulates luma per frame, divides for the mean
// at each frame start and turns (target - mean) into the filter coefficient.
module luma_auto_brightness
  import luma_auto_brightness_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = 24,
  parameter int STEP_MAX    = 0
) (
  input logic                   clk,
  input logic                   rst,
  luma_auto_brightness_if.slave bus
);

  localparam int SUM_WIDTH = PIXEL_WIDTH + CNT_WIDTH;
  localparam logic signed [COE_WIDTH-1:0] STEP = COE_WIDTH'(STEP_MAX);

  logic                        vs_q;
  logic                        sof;
  logic [SUM_WIDTH-1:0]        sum;
  logic [CNT_WIDTH-1:0]        cnt;
  state_t                      state;
  logic                        div_start;
  logic                        div_busy;
  logic                        div_done;
  logic [PIXEL_WIDTH-1:0]      q;
  logic [PIXEL_WIDTH:0]        err;
  logic signed [COE_WIDTH-1:0] err_coe;
  logic signed [COE_WIDTH-1:0] coe_cur;
  logic signed [COE_WIDTH-1:0] delta;
  logic signed [COE_WIDTH-1:0] coe_next;

  assign sof = bus.vs_i & ~vs_q;
  // The divider latches sum/cnt at start, so its registers act as the frame snapshot.
  assign div_start = sof && (state == ST_IDLE) && !div_busy && (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q <= 1'b0;
      sum  <= '0;
      cnt  <= '0;
    end else begin
      vs_q <= bus.vs_i;
      if (sof) begin
        sum <= bus.de_i ? SUM_WIDTH'(bus.y_i) : '0;
        cnt <= bus.de_i ? CNT_WIDTH'(1) : '0;
      end else if (bus.de_i) begin
        sum <= sum + SUM_WIDTH'(bus.y_i);
        if (cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

  udiv_seq #(
    .DIVIDEND_WIDTH(SUM_WIDTH),
    .DIVISOR_WIDTH (CNT_WIDTH),
    .QUOTIENT_WIDTH(PIXEL_WIDTH)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(sum),
    .divisor (cnt),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(q)
  );

  assign err     = {1'b0, bus.target_i} - {1'b0, q};
  assign err_coe = signed'(sext_coe(COE_WIDTH'(err), PIXEL_WIDTH + 1));
  assign coe_cur = signed'(bus.coe_o);
  assign delta   = err_coe - coe_cur;

  always_comb begin
    coe_next = err_coe;
    if (STEP_MAX != 0) begin
      if (delta > STEP)       coe_next = coe_cur + STEP;
      else if (delta < -STEP) coe_next = coe_cur - STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      bus.mean_o    <= '0;
      bus.coe_o     <= '0;
      bus.upd_o     <= 1'b0;
      bus.empty_o   <= 1'b0;
      bus.overrun_o <= 1'b0;
    end else begin
      bus.upd_o   <= 1'b0;
      bus.empty_o <= 1'b0;
      if (sof && (state != ST_IDLE)) bus.overrun_o <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (div_start)               state       <= ST_DIV;
          else if (sof && cnt == '0)   bus.empty_o <= 1'b1;
        end
        ST_DIV: begin
          if (div_done) state <= ST_UPD;
        end
        ST_UPD: begin
          bus.mean_o <= q;
          if (bus.en_i) bus.coe_o <= coe_next;
          bus.upd_o  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_luma_auto_brightness.sv
// Drives two controllers (unlimited and STEP_MAX=16) with the same video stream and
// compares them against a frame-level arithmetic model plus a table of known results.
module tb_luma_auto_brightness;

  localparam int LAT  = 34;
  localparam int STEP = 16;
  localparam int NVEC = 9;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  luma_auto_brightness_if #(.PIXEL_WIDTH(8)) ifc0 ();
  luma_auto_brightness_if #(.PIXEL_WIDTH(8)) ifc1 ();

  luma_auto_brightness #(.PIXEL_WIDTH(8), .CNT_WIDTH(24), .STEP_MAX(0)) dut0 (
    .clk(clk), .rst(rst), .bus(ifc0.slave)
  );
  luma_auto_brightness #(.PIXEL_WIDTH(8), .CNT_WIDTH(24), .STEP_MAX(STEP)) dut1 (
    .clk(clk), .rst(rst), .bus(ifc1.slave)
  );

  typedef struct {
    int cyc;
    int mean;
    int coe0;
    int coe1;
  } exp_t;

  typedef struct {
    int y;
    int npix;
    int target;
    bit en;
    int exp_mean;
    int exp_coe0;
    int exp_coe1;
  } vec_t;

  exp_t exp_q[$];
  int   empty_q[$];
  exp_t mon_e;
  vec_t vecs[NVEC];
  int   px[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int empty_seen = 0;
  int m_sum, m_cnt, m_coe0, m_coe1, m_last_start, cur_target;
  bit m_vs_prev, m_overrun, cur_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    m_sum        = 0;
    m_cnt        = 0;
    m_coe0       = 0;
    m_coe1       = 0;
    m_last_start = -1000;
    m_vs_prev    = 1'b0;
    m_overrun    = 1'b0;
    exp_q.delete();
    empty_q.delete();
  endtask

  task automatic setCtrl(input int target, input bit en);
    cur_target    = target;
    cur_en        = en;
    ifc0.target_i = 8'(target);
    ifc1.target_i = 8'(target);
    ifc0.en_i     = en;
    ifc1.en_i     = en;
  endtask

  // One pixel-clock cycle of stimulus; frame results are predicted at each rising vsync.
  task automatic applyStimulus(input bit v, input bit d, input int y);
    int sof_cyc, mean, err, delta;
    exp_t e;
    ifc0.vs_i = v; ifc0.de_i = d; ifc0.hs_i = ~d; ifc0.y_i = 8'(y);
    ifc1.vs_i = v; ifc1.de_i = d; ifc1.hs_i = ~d; ifc1.y_i = 8'(y);
    if (v && !m_vs_prev) begin
      sof_cyc = cyc + 1;
      if (sof_cyc - m_last_start <= LAT) begin
        m_overrun = 1'b1;
      end else if (m_cnt == 0) begin
        empty_q.push_back(sof_cyc);
      end else begin
        mean = m_sum / m_cnt;
        err  = cur_target - mean;
        if (cur_en) begin
          m_coe0 = err;
          delta  = err - m_coe1;
          if (delta > STEP) delta = STEP;
          if (delta < -STEP) delta = -STEP;
          m_coe1 = m_coe1 + delta;
        end
        e.cyc  = sof_cyc + LAT;
        e.mean = mean;
        e.coe0 = m_coe0;
        e.coe1 = m_coe1;
        exp_q.push_back(e);
        m_last_start = sof_cyc;
      end
      m_sum = d ? y : 0;
      m_cnt = d ? 1 : 0;
    end else if (d) begin
      m_sum += y;
      m_cnt++;
    end
    m_vs_prev = v;
    @(posedge clk);
    #1;
  endtask

  task automatic sendSof(input int hold, input bit sof_de, input int sof_y);
    applyStimulus(1'b1, sof_de, sof_y);
    for (int i = 1; i < hold; i++) applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
  endtask

  task automatic sendPixels(input int p[$]);
    for (int i = 0; i < p.size(); i++) begin
      applyStimulus(1'b0, 1'b1, p[i]);
      if (i % 4 == 3) applyStimulus(1'b0, 1'b0, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        checkOutput("upd_missing", 0, 1);
        exp_q.delete(0);
      end
      if (ifc0.upd_o || ifc1.upd_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("upd_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("upd_cycle", cyc, mon_e.cyc);
          checkOutput("upd0", int'(ifc0.upd_o), 1);
          checkOutput("upd1", int'(ifc1.upd_o), 1);
          checkOutput("mean0", int'(ifc0.mean_o), mon_e.mean);
          checkOutput("mean1", int'(ifc1.mean_o), mon_e.mean);
          checkOutput("coe0", int'($signed(ifc0.coe_o)), mon_e.coe0);
          checkOutput("coe1", int'($signed(ifc1.coe_o)), mon_e.coe1);
        end
      end
      if (empty_q.size() > 0 && cyc > empty_q[0]) begin
        checkOutput("empty_missing", 0, 1);
        empty_q.delete(0);
      end
      if (ifc0.empty_o || ifc1.empty_o) begin
        empty_seen++;
        if (empty_q.size() == 0) begin
          checkOutput("empty_unexpected", 1, 0);
        end else begin
          checkOutput("empty_cycle", cyc, empty_q.pop_front());
          checkOutput("empty0", int'(ifc0.empty_o), 1);
          checkOutput("empty1", int'(ifc1.empty_o), 1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0;
    //          y    n  tgt en mean  coe0  coe1
    vecs[0] = '{100, 8, 128, 1, 100,   28,  16};
    vecs[1] = '{200, 8, 128, 1, 200,  -72,   0};
    vecs[2] = '{128, 8, 128, 1, 128,    0,   0};
    vecs[3] = '{100, 8, 128, 1, 100,   28,  16};
    vecs[4] = '{100, 6, 128, 1, 100,   28,  28};
    vecs[5] = '{100, 5, 128, 1, 100,   28,  28};
    vecs[6] = '{ 50, 7, 100, 0,  50,   28,  28};
    vecs[7] = '{255, 4,   0, 1, 255, -255,  12};
    vecs[8] = '{  0, 9, 255, 1,   0,  255,  28};

    rst = 1'b1;
    modelReset();
    setCtrl(128, 1'b1);
    ifc0.vs_i = 1'b0; ifc0.de_i = 1'b0; ifc0.hs_i = 1'b0; ifc0.y_i = '0;
    ifc1.vs_i = 1'b0; ifc1.de_i = 1'b0; ifc1.hs_i = 1'b0; ifc1.y_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_coe0", int'(ifc0.coe_o), 0);
    checkOutput("rst_coe1", int'(ifc1.coe_o), 0);
    checkOutput("rst_mean", int'(ifc0.mean_o), 0);
    checkOutput("rst_upd", int'(ifc0.upd_o), 0);
    checkOutput("rst_empty", int'(ifc0.empty_o), 0);
    checkOutput("rst_overrun", int'(ifc0.overrun_o), 0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      setCtrl(vecs[i].target, vecs[i].en);
      px.delete();
      repeat (vecs[i].npix) px.push_back(vecs[i].y);
      sendSof(2, 1'b0, 0);
      sendPixels(px);
      idle(4);
      sendSof(3, 1'b0, 0);
      idle(38);
      checkOutput("vec_mean", int'(ifc0.mean_o), vecs[i].exp_mean);
      checkOutput("vec_coe0", int'($signed(ifc0.coe_o)), vecs[i].exp_coe0);
      checkOutput("vec_coe1", int'($signed(ifc1.coe_o)), vecs[i].exp_coe1);
    end

    // floor(5/3), then the sof-cycle pixel 9 must land in the following frame
    setCtrl(128, 1'b1);
    sendSof(1, 1'b0, 0);
    px = {1, 2, 2};
    sendPixels(px);
    idle(2);
    sendSof(1, 1'b1, 9);
    idle(38);
    checkOutput("floor_mean", int'(ifc0.mean_o), 1);
    px = {3};
    sendPixels(px);
    sendSof(1, 1'b0, 0);
    idle(38);
    checkOutput("sof_pixel_mean", int'(ifc0.mean_o), 6);

    // second frame start three clocks after the first
    sendSof(1, 1'b0, 0);
    px = {10, 10, 10, 10};
    sendPixels(px);
    sendSof(1, 1'b0, 0);
    px = {50};
    sendPixels(px);
    sendSof(1, 1'b0, 0);
    idle(40);
    checkOutput("overrun_set0", int'(ifc0.overrun_o), 1);
    checkOutput("overrun_set1", int'(ifc1.overrun_o), 1);
    checkOutput("overrun_first_mean", int'(ifc0.mean_o), 10);
    px = {60, 60};
    sendPixels(px);
    sendSof(1, 1'b0, 0);
    idle(40);
    checkOutput("after_overrun_mean", int'(ifc0.mean_o), 60);
    checkOutput("overrun_sticky", int'(ifc0.overrun_o), 1);

    e0 = empty_seen;
    sendSof(1, 1'b0, 0);
    idle(40);
    checkOutput("empty_count", empty_seen, e0 + 1);
    checkOutput("empty_coe0", int'($signed(ifc0.coe_o)), m_coe0);
    checkOutput("empty_coe1", int'($signed(ifc1.coe_o)), m_coe1);

    // asynchronous reset while the divider is running
    px = {90, 90, 90, 90};
    sendPixels(px);
    sendSof(1, 1'b0, 0);
    idle(10);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_coe0", int'(ifc0.coe_o), 0);
    checkOutput("arst_coe1", int'(ifc1.coe_o), 0);
    checkOutput("arst_mean", int'(ifc0.mean_o), 0);
    checkOutput("arst_overrun", int'(ifc0.overrun_o), 0);
    checkOutput("arst_upd", int'(ifc0.upd_o), 0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sendSof(1, 1'b0, 0);
    px = {70, 70, 70, 70};
    sendPixels(px);
    sendSof(1, 1'b0, 0);
    idle(38);
    checkOutput("post_rst_mean", int'(ifc0.mean_o), 70);
    checkOutput("post_rst_coe0", int'($signed(ifc0.coe_o)), 58);
    checkOutput("post_rst_coe1", int'($signed(ifc1.coe_o)), 16);

    for (int f = 0; f < 20; f++) begin
      int n;
      setCtrl(int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
      px.delete();
      n = int'($urandom_range(1, 12));
      repeat (n) px.push_back(int'($urandom_range(0, 255)));
      sendSof(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      sendPixels(px);
      idle(40);
    end
    sendSof(1, 1'b0, 0);
    idle(40);

    checkOutput("exp_drained", exp_q.size(), 0);
    checkOutput("empty_drained", empty_q.size(), 0);
    checkOutput("final_overrun", int'(ifc0.overrun_o), int'(m_overrun));
    checkOutput("final_coe0", int'($signed(ifc0.coe_o)), m_coe0);
    checkOutput("final_coe1", int'($signed(ifc1.coe_o)), m_coe1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
